renderer_rect_sequencer: RTL



---
 rtl/renderer_rect_sequencer_if.sv | 48 ++++
 rtl/renderer_rect_sequencer.sv | 133 +++++++++++++
 2 files changed

// File: rtl/renderer_rect_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module      : renderer_rect_sequencer_if
//  Description : Command and line-filler handshake bundle for the rectangle
//                sequencer. Signal prefixes are from the sequencer's view.
//  Revision    : 1.0  initial release
// ============================================================================
interface renderer_rect_sequencer_if;
    // command channel
    logic        i_cmd_valid;
    logic        o_cmd_ready;
    logic [9:0]  i_cmd_x1;
    logic [9:0]  i_cmd_y1;
    logic [9:0]  i_cmd_x2;
    logic [9:0]  i_cmd_y2;
    logic [11:0] i_cmd_color;
    // line-filler channel
    logic [9:0]  o_line_x1;
    logic [9:0]  o_line_x2;
    logic [9:0]  o_line_address;
    logic [3:0]  o_color_red;
    logic [3:0]  o_color_green;
    logic [3:0]  o_color_blue;
    logic        o_line_start;
    logic        i_line_done;
    // status
    logic        o_busy;
    logic        o_rect_done;

    // sequencer side
    modport master (
        input  i_cmd_valid, i_cmd_x1, i_cmd_y1, i_cmd_x2, i_cmd_y2, i_cmd_color,
        input  i_line_done,
        output o_cmd_ready, o_line_x1, o_line_x2, o_line_address,
        output o_color_red, o_color_green, o_color_blue,
        output o_line_start, o_busy, o_rect_done
    );

    // command source / line filler side
    modport slave (
        output i_cmd_valid, i_cmd_x1, i_cmd_y1, i_cmd_x2, i_cmd_y2, i_cmd_color,
        output i_line_done,
        input  o_cmd_ready, o_line_x1, o_line_x2, o_line_address,
        input  o_color_red, o_color_green, o_color_blue,
        input  o_line_start, o_busy, o_rect_done
    );
endinterface
`default_nettype wire

// File: rtl/renderer_rect_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : renderer_rect_sequencer
//  Description : Accepts one filled-rectangle command, normalises and clips it
//                to the screen, then issues one line-fill job per row (top to
//                bottom) to the line filler. Pulses o_rect_done at the end.
//  Revision    : 1.0  initial release
// ============================================================================
module renderer_rect_sequencer #(
    parameter int SCREEN_WIDTH  = 640,
    parameter int SCREEN_HEIGHT = 480
) (
    input  logic                       i_master_clk,
    input  logic                       i_reset,
    renderer_rect_sequencer_if.master  io_bus
);

    localparam logic [2:0] c_ST_IDLE  = 3'd0;
    localparam logic [2:0] c_ST_CLIP  = 3'd1;
    localparam logic [2:0] c_ST_START = 3'd2;
    localparam logic [2:0] c_ST_WAIT  = 3'd3;
    localparam logic [2:0] c_ST_NEXT  = 3'd4;
    localparam logic [2:0] c_ST_DONE  = 3'd5;

    // 11-bit limits so a 1024-wide/high screen still compares correctly
    localparam logic [10:0] c_X_LIMIT = 11'(SCREEN_WIDTH);
    localparam logic [10:0] c_Y_LIMIT = 11'(SCREEN_HEIGHT);
    localparam logic [9:0]  c_X_LAST  = 10'(SCREEN_WIDTH - 1);
    localparam logic [9:0]  c_Y_LAST  = 10'(SCREEN_HEIGHT - 1);

    logic [2:0]  r_state;
    logic [2:0]  w_state_next;

    logic [9:0]  r_raw_x1, r_raw_y1, r_raw_x2, r_raw_y2;
    logic [11:0] r_raw_color;
    logic [9:0]  r_line_x1, r_line_x2, r_line_address, r_ymax;
    logic [3:0]  r_red, r_green, r_blue;

    logic [9:0]  w_xmin, w_xmax, w_ymin, w_ymax;
    logic [9:0]  w_xmax_clip, w_ymax_clip;
    logic        w_empty;
    logic        w_last_row;

    // normalise corners and clip against the visible area
    assign w_xmin      = (r_raw_x1 < r_raw_x2) ? r_raw_x1 : r_raw_x2;
    assign w_xmax      = (r_raw_x1 < r_raw_x2) ? r_raw_x2 : r_raw_x1;
    assign w_ymin      = (r_raw_y1 < r_raw_y2) ? r_raw_y1 : r_raw_y2;
    assign w_ymax      = (r_raw_y1 < r_raw_y2) ? r_raw_y2 : r_raw_y1;
    assign w_empty     = ({1'b0, w_xmin} >= c_X_LIMIT) || ({1'b0, w_ymin} >= c_Y_LIMIT);
    assign w_xmax_clip = (w_xmax > c_X_LAST) ? c_X_LAST : w_xmax;
    assign w_ymax_clip = (w_ymax > c_Y_LAST) ? c_Y_LAST : w_ymax;
    assign w_last_row  = (r_line_address == r_ymax);

    // state register
    always_ff @(posedge i_master_clk) begin
        if (i_reset) r_state <= c_ST_IDLE;
        else         r_state <= w_state_next;
    end

    // next-state decode
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_ST_IDLE:  if (io_bus.i_cmd_valid) w_state_next = c_ST_CLIP;
            c_ST_CLIP:  w_state_next = w_empty ? c_ST_DONE : c_ST_START;
            c_ST_START: w_state_next = c_ST_WAIT;
            c_ST_WAIT:  if (io_bus.i_line_done) w_state_next = c_ST_NEXT;
            c_ST_NEXT:  w_state_next = w_last_row ? c_ST_DONE : c_ST_START;
            c_ST_DONE:  w_state_next = c_ST_IDLE;
            default:    w_state_next = c_ST_IDLE;
        endcase
    end

    // command capture, clipped line setup and row stepping
    always_ff @(posedge i_master_clk) begin
        if (i_reset) begin
            r_raw_x1       <= '0;
            r_raw_y1       <= '0;
            r_raw_x2       <= '0;
            r_raw_y2       <= '0;
            r_raw_color    <= '0;
            r_line_x1      <= '0;
            r_line_x2      <= '0;
            r_line_address <= '0;
            r_ymax         <= '0;
            r_red          <= '0;
            r_green        <= '0;
            r_blue         <= '0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (io_bus.i_cmd_valid) begin
                        r_raw_x1    <= io_bus.i_cmd_x1;
                        r_raw_y1    <= io_bus.i_cmd_y1;
                        r_raw_x2    <= io_bus.i_cmd_x2;
                        r_raw_y2    <= io_bus.i_cmd_y2;
                        r_raw_color <= io_bus.i_cmd_color;
                    end
                end
                c_ST_CLIP: begin
                    // empty commands leave the line outputs untouched
                    if (!w_empty) begin
                        r_line_x1      <= w_xmin;
                        r_line_x2      <= w_xmax_clip;
                        r_line_address <= w_ymin;
                        r_ymax         <= w_ymax_clip;
                        r_red          <= r_raw_color[11:8];
                        r_green        <= r_raw_color[7:4];
                        r_blue         <= r_raw_color[3:0];
                    end
                end
                c_ST_NEXT: begin
                    // ymax never exceeds SCREEN_HEIGHT-1, so this cannot wrap
                    if (!w_last_row) r_line_address <= r_line_address + 10'd1;
                end
                default: ;
            endcase
        end
    end

    assign io_bus.o_cmd_ready    = (r_state == c_ST_IDLE);
    assign io_bus.o_busy         = (r_state != c_ST_IDLE);
    assign io_bus.o_line_start   = (r_state == c_ST_START);
    assign io_bus.o_rect_done    = (r_state == c_ST_DONE);
    assign io_bus.o_line_x1      = r_line_x1;
    assign io_bus.o_line_x2      = r_line_x2;
    assign io_bus.o_line_address = r_line_address;
    assign io_bus.o_color_red    = r_red;
    assign io_bus.o_color_green  = r_green;
    assign io_bus.o_color_blue   = r_blue;

endmodule
`default_nettype wire
